// File: rtl/imm_gen_ctrl.sv
// imm_gen_ctrl: two-stage elastic immediate generator for the LEGv8 core.
// S1 captures the instruction and its decoded format; S2 holds the extended,
// shifted immediate and its side-band outputs. Valid/ready on both sides.
// Optional feature macro: IMM_GEN_MOVK_MASK_EN (compiles in the movk_mask
// register; when undefined movk_mask is tied to zero).
module imm_gen_ctrl #(
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [63:0]        imm,
    output logic [2:0]         imm_kind,
    output logic [63:0]        movk_mask,
    output logic               illegal
);

    typedef enum logic [2:0] {
        KIND_NONE = 3'd0,
        KIND_D    = 3'd1,
        KIND_I    = 3'd2,
        KIND_CB   = 3'd3,
        KIND_B    = 3'd4,
        KIND_IM   = 3'd5
    } kind_e;

    // Format classification; earlier formats win when opcodes overlap.
    function automatic kind_e decode_kind(input logic [INSTR_W-1:0] w);
        logic  is_b, is_cb, is_d, is_i, is_im;
        kind_e k;
        is_b  = (w[31:26] == 6'b000101) || (w[31:26] == 6'b100101);
        is_cb = (w[31:24] == 8'b10110100) || (w[31:24] == 8'b10110101) ||
                (w[31:24] == 8'b01010100);
        is_d  = (w[31:21] == 11'b11111000010) || (w[31:21] == 11'b11111000000);
        case (w[31:22])
            10'b1001000100, 10'b1011000100, 10'b1101000100, 10'b1111000100,
            10'b1001001000, 10'b1011001000, 10'b1101001000: is_i = 1'b1;
            default:                                        is_i = 1'b0;
        endcase
        is_im = (w[31:23] == 9'b110100101) || (w[31:23] == 9'b111100101);
        if (is_b)       k = KIND_B;
        else if (is_cb) k = KIND_CB;
        else if (is_d)  k = KIND_D;
        else if (is_i)  k = KIND_I;
        else if (is_im) k = KIND_IM;
        else            k = KIND_NONE;
        return k;
    endfunction

    // Extension and per-format shift of the immediate field.
    function automatic logic [63:0] build_imm(input logic [INSTR_W-1:0] w, input kind_e k);
        logic [63:0] r;
        case (k)
            KIND_D:  r = {{55{w[20]}}, w[20:12]};
            KIND_I:  r = {52'd0, w[21:10]};
            KIND_CB: r = {{43{w[23]}}, w[23:5], 2'b00};
            KIND_B:  r = {{36{w[25]}}, w[25:0], 2'b00};
            KIND_IM: r = {48'd0, w[20:5]} << {w[22:21], 4'b0000};
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    // Bits of Rd that MOVK keeps; MOVK differs from MOVZ in opcode bit 29.
    function automatic logic [63:0] build_mask(input logic [INSTR_W-1:0] w, input kind_e k);
        logic [63:0] r;
        if ((k == KIND_IM) && w[29]) r = ~(64'hFFFF << {w[22:21], 4'b0000});
        else                         r = 64'd0;
        return r;
    endfunction

    logic               s1_valid_r;
    logic [INSTR_W-1:0] s1_instr_r;
    kind_e              s1_kind_r;
    logic               out_valid_r;
    logic [63:0]        imm_r;
    logic [2:0]         kind_r;
    logic               illegal_r;
    logic               s2_ready_s;
    logic               s2_load_s;
    logic               s1_load_s;
    logic               unused_s;

    // S2 can take new data when empty or when its contents leave this cycle.
    assign s2_ready_s = !out_valid_r || out_ready;
    assign s2_load_s  = s1_valid_r && s2_ready_s;
    assign in_ready   = !flush && (!s1_valid_r || s2_load_s);
    assign s1_load_s  = in_valid && in_ready;
    // Rd/Rt field travels with the instruction but carries no immediate.
    assign unused_s   = ^s1_instr_r[4:0];

    // S1: capture instruction and decoded format; flush squashes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_r <= 1'b0;
            s1_instr_r <= '0;
            s1_kind_r  <= KIND_NONE;
        end else if (flush) begin
            s1_valid_r <= 1'b0;
        end else if (s1_load_s) begin
            s1_valid_r <= 1'b1;
            s1_instr_r <= instr;
            s1_kind_r  <= decode_kind(instr);
        end else if (s2_load_s) begin
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // S2: register the immediate and side-band; held while the consumer stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_r <= 1'b0;
            imm_r       <= 64'd0;
            kind_r      <= 3'd0;
            illegal_r   <= 1'b0;
        end else if (flush) begin
            out_valid_r <= 1'b0;
        end else if (s2_load_s) begin
            out_valid_r <= 1'b1;
            imm_r       <= build_imm(s1_instr_r, s1_kind_r);
            kind_r      <= s1_kind_r;
            illegal_r   <= (s1_kind_r == KIND_NONE);
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

`ifdef IMM_GEN_MOVK_MASK_EN
    logic [63:0] mask_r;

    // S2 MOVK preserve-mask register, loaded alongside the immediate.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask_r <= 64'd0;
        end else if (!flush && s2_load_s) begin
            mask_r <= build_mask(s1_instr_r, s1_kind_r);
        end else begin
            mask_r <= mask_r;
        end
    end

    assign movk_mask = mask_r;
`else
    logic [63:0] unused_mask_s;
    assign unused_mask_s = build_mask(s1_instr_r, s1_kind_r);
    assign movk_mask     = 64'd0;
`endif

    assign out_valid = out_valid_r;
    assign imm       = imm_r;
    assign imm_kind  = kind_r;
    assign illegal   = illegal_r;

endmodule

// File: tb/tb_imm_gen_ctrl.sv
module tb_imm_gen_ctrl;

    typedef struct packed {
        logic [63:0] imm;
        logic [2:0]  kind;
        logic [63:0] mask;
        logic        ill;
    } exp_t;

`ifdef IMM_GEN_MOVK_MASK_EN
    localparam logic MASK_EN = 1'b1;
`else
    localparam logic MASK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = 32'd0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] imm;
    logic [2:0]  imm_kind;
    logic [63:0] movk_mask;
    logic        illegal;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    localparam int NV = 12;
    logic [31:0] vec_instr [NV];
    exp_t        vec_exp   [NV];

    imm_gen_ctrl #(.INSTR_W(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .imm(imm), .imm_kind(imm_kind), .movk_mask(movk_mask), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endfunction

    function automatic exp_t mk(input logic [63:0] i, input logic [2:0] k,
                                input logic [63:0] m, input logic il);
        exp_t e;
        e.imm  = i;
        e.kind = k;
        e.mask = m & {64{MASK_EN}};
        e.ill  = il;
        return e;
    endfunction

    // Monitor: just before each rising edge compare the presented output
    // with the scoreboard head; pop it only when the handshake completes.
    always begin
        exp_t e;
        @(negedge clk);
        #4;
        if (reset && out_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_output", 64'd1, 64'd0);
            end else begin
                e = sb_q[0];
                check("imm", imm, e.imm);
                check("imm_kind", {61'd0, imm_kind}, {61'd0, e.kind});
                check("movk_mask", movk_mask, e.mask);
                check("illegal", {63'd0, illegal}, {63'd0, e.ill});
                if (out_ready) void'(sb_q.pop_front());
            end
        end
    end

    // One cycle of stimulus: drive at the falling edge, decide acceptance just
    // before the rising edge and record the expected response if accepted.
    task automatic step(input logic v, input logic [31:0] w, input logic ordy,
                        input logic fl, input exp_t e, output logic acc);
        @(negedge clk);
        in_valid  = v;
        instr     = w;
        out_ready = ordy;
        flush     = fl;
        #4;
        acc = v && in_ready;
        if (acc) sb_q.push_back(e);
    endtask

    task automatic idle();
        logic a;
        step(1'b0, 32'd0, 1'b1, 1'b0, '0, a);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            idle();
            n++;
        end
        check("drain_empty", 64'(sb_q.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
        check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        check({tag, "_imm"}, imm, 64'd0);
        check({tag, "_imm_kind"}, {61'd0, imm_kind}, 64'd0);
        check({tag, "_movk_mask"}, movk_mask, 64'd0);
        check({tag, "_illegal"}, {63'd0, illegal}, 64'd0);
    endtask

    task automatic latency_test(input string tag);
        logic a;
        step(1'b1, vec_instr[0], 1'b1, 1'b0, vec_exp[0], a);
        check({tag, "_accept"}, {63'd0, a}, 64'd1);
        idle();
        check({tag, "_valid_after_1"}, {63'd0, out_valid}, 64'd0);
        idle();
        check({tag, "_valid_after_2"}, {63'd0, out_valid}, 64'd1);
        drain();
    endtask

    initial begin
        logic a;
        int   idx;
        int   acc_cnt;

        vec_instr[0]  = 32'hF85FF000; vec_exp[0]  = mk(64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 64'd0, 1'b0);
        vec_instr[1]  = 32'h913FFC00; vec_exp[1]  = mk(64'h0000_0000_0000_0FFF, 3'd2, 64'd0, 1'b0);
        vec_instr[2]  = 32'h17FFFFFF; vec_exp[2]  = mk(64'hFFFF_FFFF_FFFF_FFFC, 3'd4, 64'd0, 1'b0);
        vec_instr[3]  = 32'hB4000020; vec_exp[3]  = mk(64'h4, 3'd3, 64'd0, 1'b0);
        vec_instr[4]  = 32'hF2F579A0; vec_exp[4]  = mk(64'hABCD_0000_0000_0000, 3'd5, 64'h0000_FFFF_FFFF_FFFF, 1'b0);
        vec_instr[5]  = 32'h8B000000; vec_exp[5]  = mk(64'd0, 3'd0, 64'd0, 1'b1);
        vec_instr[6]  = 32'hD2A24680; vec_exp[6]  = mk(64'h0000_0000_1234_0000, 3'd5, 64'd0, 1'b0);
        vec_instr[7]  = 32'hB5FFFFE0; vec_exp[7]  = mk(64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 64'd0, 1'b0);
        vec_instr[8]  = 32'hF8010000; vec_exp[8]  = mk(64'h10, 3'd1, 64'd0, 1'b0);
        vec_instr[9]  = 32'h54000040; vec_exp[9]  = mk(64'h8, 3'd3, 64'd0, 1'b0);
        vec_instr[10] = 32'h94000001; vec_exp[10] = mk(64'h4, 3'd4, 64'd0, 1'b0);
        vec_instr[11] = 32'hF28AAAA0; vec_exp[11] = mk(64'h5555, 3'd5, 64'hFFFF_FFFF_FFFF_0000, 1'b0);

        // Reset state while reset is held.
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Two-cycle latency on the first instruction.
        latency_test("latency");

        // Back-to-back stream of every vector with no back-pressure.
        acc_cnt = 0;
        for (int i = 0; i < NV; i++) begin
            step(1'b1, vec_instr[i], 1'b1, 1'b0, vec_exp[i], a);
            if (a) acc_cnt++;
        end
        check("stream_accepts", 64'(acc_cnt), 64'(NV));
        drain();

        // Back-pressure: offer four instructions while the consumer stalls.
        idx = 0;
        acc_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            step(1'b1, vec_instr[idx + 1], 1'b0, 1'b0, vec_exp[idx + 1], a);
            if (a) begin
                acc_cnt++;
                idx++;
            end
        end
        check("bp_accepts", 64'(acc_cnt), 64'd2);
        check("bp_in_ready", {63'd0, in_ready}, 64'd0);
        for (int c = 0; c < 4; c++) begin
            if (idx < 4) begin
                step(1'b1, vec_instr[idx + 1], 1'b1, 1'b0, vec_exp[idx + 1], a);
                if (a) idx++;
            end else begin
                idle();
            end
            check("bp_release_valid", {63'd0, out_valid}, 64'd1);
        end
        check("bp_total_accepts", 64'(idx), 64'd4);
        drain();

        // Flush with both stages full; the input offered alongside is refused.
        step(1'b1, vec_instr[2], 1'b0, 1'b0, vec_exp[2], a);
        step(1'b1, vec_instr[3], 1'b0, 1'b0, vec_exp[3], a);
        step(1'b1, vec_instr[4], 1'b0, 1'b1, vec_exp[4], a);
        check("flush_accept", {63'd0, a}, 64'd0);
        check("flush_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        sb_q.delete();
        idle();
        check("flush_out_valid", {63'd0, out_valid}, 64'd0);
        repeat (3) idle();

        // Reset asserted mid-stream clears outputs without a clock edge.
        step(1'b1, vec_instr[0], 1'b1, 1'b0, vec_exp[0], a);
        step(1'b1, vec_instr[1], 1'b1, 1'b0, vec_exp[1], a);
        #2;
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        check_reset_outputs("midreset");
        sb_q.delete();
        @(negedge clk);
        reset = 1'b1;
        latency_test("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
